// File: rtl/des_result_serializer.sv
// Buffers up to two 64-bit DES result blocks and hands them out as 16-bit words
// through a PipeOut-style read strobe, counting fully read blocks.
module des_result_serializer #(
  parameter bit SWAP_WORDS = 1'b0
) (
  input  logic        clk1,
  input  logic        reset,
  input  logic [63:0] blk_data,
  input  logic        blk_valid,
  output logic        blk_ready,
  input  logic        pipe_read,
  output logic [15:0] pipe_data,
  output logic        word_avail,
  output logic [3:0]  words_pending,
  output logic [15:0] blocks_sent,
  output logic        underflow,
  output logic [1:0]  state_dbg
);

  // Handshake: a block moves on a rising edge where blk_valid && blk_ready;
  // blk_ready comes from registered occupancy only, and the source holds
  // blk_data until it is taken. A word is consumed by pipe_read while word_avail.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] mem [2];
  logic        wptr_q, rptr_q;
  logic [1:0]  widx_q;
  logic [15:0] sent_q;
  logic        underflow_q;

  logic        accept, rd, pop;
  logic [1:0]  count, k;
  logic [63:0] head;

  assign count      = state_q;
  assign state_dbg  = state_q;
  assign blk_ready  = (state_q != FULL) && !reset;
  assign word_avail = (state_q != EMPTY);
  assign accept     = blk_valid && blk_ready;
  assign rd         = pipe_read && word_avail;
  assign pop        = rd && (widx_q == 2'd3);

  assign head       = mem[rptr_q];
  assign k          = SWAP_WORDS ? (2'd3 - widx_q) : widx_q;
  assign pipe_data  = word_avail ? head[{k, 4'b0000} +: 16] : 16'h0000;

  // widx is always 0 when empty, so this never goes negative.
  assign words_pending = {count, 2'b00} - {2'b00, widx_q};
  assign blocks_sent   = sent_q;
  assign underflow     = underflow_q;

  always_comb begin
    state_d = state_q;
    if (accept && !pop) begin
      case (state_q)
        EMPTY:   state_d = ONE;
        ONE:     state_d = FULL;
        default: state_d = state_q;
      endcase
    end else if (pop && !accept) begin
      case (state_q)
        FULL:    state_d = ONE;
        ONE:     state_d = EMPTY;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk1) begin
    if (reset) begin
      state_q     <= EMPTY;
      wptr_q      <= 1'b0;
      rptr_q      <= 1'b0;
      widx_q      <= 2'd0;
      sent_q      <= 16'h0000;
      underflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) wptr_q <= ~wptr_q;
      if (rd) widx_q <= widx_q + 2'd1;
      if (pop) begin
        rptr_q <= ~rptr_q;
        sent_q <= sent_q + 16'd1;
      end
      if (pipe_read && !word_avail) underflow_q <= 1'b1;
    end
  end

  // Storage is never cleared; word_avail gates everything read from it.
  always_ff @(posedge clk1) begin
    if (accept) mem[wptr_q] <= blk_data;
  end

endmodule

// File: tb/tb_des_result_serializer.sv
// Directed bench for des_result_serializer: one instance per word order,
// both driven by the same stimulus, with hand-computed expectations.
module tb_des_result_serializer;

  logic        clk1 = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] blk_data = 64'h0;
  logic        blk_valid = 1'b0;
  logic        pipe_read = 1'b0;

  logic        blk_ready0, word_avail0, underflow0;
  logic [15:0] pipe_data0, blocks_sent0;
  logic [3:0]  words_pending0;
  logic [1:0]  state_dbg0;

  logic        blk_ready1, word_avail1, underflow1;
  logic [15:0] pipe_data1, blocks_sent1;
  logic [3:0]  words_pending1;
  logic [1:0]  state_dbg1;

  int passed = 0;
  int total  = 0;

  always #5 clk1 = ~clk1;

  des_result_serializer #(.SWAP_WORDS(1'b0)) dut0 (
    .clk1(clk1), .reset(reset), .blk_data(blk_data), .blk_valid(blk_valid),
    .blk_ready(blk_ready0), .pipe_read(pipe_read), .pipe_data(pipe_data0),
    .word_avail(word_avail0), .words_pending(words_pending0),
    .blocks_sent(blocks_sent0), .underflow(underflow0), .state_dbg(state_dbg0)
  );

  des_result_serializer #(.SWAP_WORDS(1'b1)) dut1 (
    .clk1(clk1), .reset(reset), .blk_data(blk_data), .blk_valid(blk_valid),
    .blk_ready(blk_ready1), .pipe_read(pipe_read), .pipe_data(pipe_data1),
    .word_avail(word_avail1), .words_pending(words_pending1),
    .blocks_sent(blocks_sent1), .underflow(underflow1), .state_dbg(state_dbg1)
  );

  task automatic tick;
    @(posedge clk1);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send_block(input logic [63:0] b);
    blk_data  = b;
    blk_valid = 1'b1;
    tick();
    blk_valid = 1'b0;
  endtask

  // Reads n words starting at word index first, checking both word orders.
  task automatic read_words(input string tag, input logic [63:0] b, input int first, input int n);
    logic [63:0] v;
    v = b;
    pipe_read = 1'b1;
    for (int i = first; i < first + n; i++) begin
      check({tag, "_w0"}, {48'h0, pipe_data0}, {48'h0, v[16*i +: 16]});
      check({tag, "_w1"}, {48'h0, pipe_data1}, {48'h0, v[16*(3-i) +: 16]});
      tick();
    end
    pipe_read = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_ready", {63'h0, blk_ready0}, 64'h0);
    check("rst_avail", {63'h0, word_avail0}, 64'h0);
    check("rst_data", {48'h0, pipe_data0}, 64'h0);
    check("rst_pending", {60'h0, words_pending0}, 64'h0);
    check("rst_sent", {48'h0, blocks_sent0}, 64'h0);
    check("rst_underflow", {63'h0, underflow0}, 64'h0);
    reset = 1'b0;
    #1;
    check("ready_after_rst", {63'h0, blk_ready0}, 64'h1);

    // Single block, both word orders
    send_block(64'h0123_4567_89AB_CDEF);
    check("single_avail", {63'h0, word_avail0}, 64'h1);
    check("single_pending", {60'h0, words_pending0}, 64'h4);
    check("single_first0", {48'h0, pipe_data0}, 64'hCDEF);
    check("single_first1", {48'h0, pipe_data1}, 64'h0123);
    read_words("single", 64'h0123_4567_89AB_CDEF, 0, 4);
    check("single_avail_after", {63'h0, word_avail0}, 64'h0);
    check("single_sent", {48'h0, blocks_sent0}, 64'h1);
    check("single_sent1", {48'h0, blocks_sent1}, 64'h1);
    check("single_data_after", {48'h0, pipe_data0}, 64'h0);

    // Backpressure: third block waits until the head drains
    send_block(64'h1111_2222_3333_4444);
    send_block(64'h5555_6666_7777_8888);
    check("bp_ready_full", {63'h0, blk_ready0}, 64'h0);
    check("bp_pending_8", {60'h0, words_pending0}, 64'h8);
    check("bp_state_full", {62'h0, state_dbg0}, 64'h2);
    blk_data  = 64'h9999_AAAA_BBBB_CCCC;
    blk_valid = 1'b1;
    tick();
    check("bp_ignored", {60'h0, words_pending0}, 64'h8);
    read_words("bp_a", 64'h1111_2222_3333_4444, 0, 4);
    check("bp_ready_after_drain", {63'h0, blk_ready0}, 64'h1);
    check("bp_pending_4", {60'h0, words_pending0}, 64'h4);
    tick();
    blk_valid = 1'b0;
    check("bp_third_taken", {60'h0, words_pending0}, 64'h8);
    check("bp_ready_again0", {63'h0, blk_ready0}, 64'h0);
    read_words("bp_b", 64'h5555_6666_7777_8888, 0, 4);
    read_words("bp_c", 64'h9999_AAAA_BBBB_CCCC, 0, 4);
    check("bp_empty", {63'h0, word_avail0}, 64'h0);
    check("bp_sent", {48'h0, blocks_sent0}, 64'h4);

    // Simultaneous accept and pop from ONE
    send_block(64'hDDDD_0001_0002_0003);
    read_words("sim_d", 64'hDDDD_0001_0002_0003, 0, 3);
    check("sim_pending_1", {60'h0, words_pending0}, 64'h1);
    check("sim_last_word", {48'h0, pipe_data0}, 64'hDDDD);
    blk_data  = 64'hEEEE_EEE1_EEE2_EEE3;
    blk_valid = 1'b1;
    pipe_read = 1'b1;
    tick();
    blk_valid = 1'b0;
    pipe_read = 1'b0;
    check("sim_state_one", {62'h0, state_dbg0}, 64'h1);
    check("sim_pending_4", {60'h0, words_pending0}, 64'h4);
    check("sim_new_word0", {48'h0, pipe_data0}, 64'hEEE3);
    check("sim_new_word0_swap", {48'h0, pipe_data1}, 64'hEEEE);
    check("sim_sent", {48'h0, blocks_sent0}, 64'h5);
    read_words("sim_e", 64'hEEEE_EEE1_EEE2_EEE3, 0, 4);
    check("sim_sent_after", {48'h0, blocks_sent0}, 64'h6);

    // Underflow is sticky and leaves state alone
    pipe_read = 1'b1;
    tick();
    pipe_read = 1'b0;
    check("uf_flag", {63'h0, underflow0}, 64'h1);
    check("uf_sent", {48'h0, blocks_sent0}, 64'h6);
    check("uf_pending", {60'h0, words_pending0}, 64'h0);
    tick();
    check("uf_sticky", {63'h0, underflow0}, 64'h1);

    // Reset with 1.5 blocks buffered; inputs during reset are ignored
    send_block(64'hF00D_F00C_F00B_F00A);
    send_block(64'hABCD_1234_5678_9ABC);
    read_words("pre_rst", 64'hF00D_F00C_F00B_F00A, 0, 2);
    check("pre_rst_pending", {60'h0, words_pending0}, 64'h6);
    reset     = 1'b1;
    blk_data  = 64'h1234_5678_9ABC_DEF0;
    blk_valid = 1'b1;
    pipe_read = 1'b1;
    tick();
    check("mid_rst_ready", {63'h0, blk_ready0}, 64'h0);
    reset     = 1'b0;
    blk_valid = 1'b0;
    pipe_read = 1'b0;
    #1;
    check("post_rst_avail", {63'h0, word_avail0}, 64'h0);
    check("post_rst_data", {48'h0, pipe_data0}, 64'h0);
    check("post_rst_pending", {60'h0, words_pending0}, 64'h0);
    check("post_rst_sent", {48'h0, blocks_sent0}, 64'h0);
    check("post_rst_underflow", {63'h0, underflow0}, 64'h0);
    check("post_rst_state", {62'h0, state_dbg0}, 64'h0);
    check("post_rst_ready", {63'h0, blk_ready0}, 64'h1);

    // blocks_sent wrap, preloaded close to the top
    force dut0.sent_q = 16'hFFFE;
    #1;
    release dut0.sent_q;
    send_block(64'h0F0F_1E1E_2D2D_3C3C);
    read_words("wrap_a", 64'h0F0F_1E1E_2D2D_3C3C, 0, 4);
    check("wrap_ffff", {48'h0, blocks_sent0}, 64'hFFFF);
    send_block(64'h4B4B_5A5A_6969_7878);
    read_words("wrap_b", 64'h4B4B_5A5A_6969_7878, 0, 4);
    check("wrap_zero", {48'h0, blocks_sent0}, 64'h0);
    check("wrap_no_flag", {63'h0, underflow0}, 64'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
